smem_result_packer: RTL and testbench
=====================================

# smem_result_packer

Packs the 65-bit records popped from the single-read SMEM output FIFO into wide multi-record lines for the host write path. It drives the FIFO's `stall` input so the pop-then-valid read latency never drops a record. It delivers full lines, or partial lines on flush, over a valid/ready output handshake. It sits directly downstream of the 2-write/1-read SMEM FIFO.

## Interface

**Parameters**
- `DATA_WIDTH`, 65: record width; must match the FIFO.
- `PACK_COUNT`, 4: records per output line, ≥2.
- `COUNT_WIDTH`, 3: width of `Out_count`; must satisfy 2^COUNT_WIDTH > PACK_COUNT.

**Ports** (one clock; reset is synchronous and active-high)
- `Clk` in 1: clock, shared with the FIFO read side.
- `Clear_in` in 1: synchronous active-high reset.
- `Data_in` in DATA_WIDTH: FIFO `Data_out`.
- `Data_valid_in` in 1: FIFO `Data_valid`.
- `Empty_in` in 1: FIFO `Empty_out`.
- `stall_out` out 1: to FIFO `stall`. High means no pop this cycle.
- `flush_in` in 1: pulse requesting drain and emission of a partial line.
- `Out_data` out DATA_WIDTH*PACK_COUNT: packed line. Slot k is bits [k*DATA_WIDTH +: DATA_WIDTH]; slot 0 is the oldest record.
- `Out_count` out COUNT_WIDTH: valid slots in `Out_data`, 1..PACK_COUNT.
- `Out_valid` out 1: line available.
- `Out_ready` in 1: consumer accepts the line when `Out_valid` and `Out_ready` are both high.
- `Overflow_out` out 1: sticky error flag. Set when a record arrives while the skid buffer is full.
- `flush_done_out` out 1: one-cycle pulse when a flush completes.

## Operation
- **Storage**
  - Accumulator: PACK_COUNT slots plus fill count `acc_cnt`.
  - Skid FIFO: 2 entries, in order.
  - Output register: holds one line.
- **Intake, one record per cycle**
  - If the skid FIFO is non-empty, its head goes to the accumulator.
  - Otherwise `Data_in` goes to the accumulator when `Data_valid_in` is high.
  - A `Data_valid_in` record that cannot enter the accumulator this cycle goes to the skid tail.
  - Record order is preserved end to end.
- **Accumulator blocked**: the accumulator accepts nothing while `acc_cnt == PACK_COUNT`.
- **Line transfer**: a full accumulator moves to the output register when the register is free, or is being freed by a handshake in the same cycle. `acc_cnt` then becomes 0, or 1 if a record enters in the same cycle.
- **Stall**: `stall_out = (skid_cnt != 0) || (acc_cnt == PACK_COUNT && output register busy and not handshaking)`. It is combinational from registered state. Because of the FIFO's one-cycle pop→valid latency, at most one record arrives after stall rises, so 2 skid entries suffice.
- **Overflow**: `Data_valid_in` with `skid_cnt == 2` sets `Overflow_out` and drops the record.
- **Flush state machine**
  - `IDLE`: `flush_in` → `FLUSH_WAIT`.
  - `FLUSH_WAIT`: waits for `Empty_in=1`, `Data_valid_in=0`, `skid_cnt=0` and the output register free.
    - If `acc_cnt>0`: emit a partial line. `Out_count=acc_cnt`, unused slots are zero. Go to `IDLE` and pulse `flush_done_out`.
    - If `acc_cnt=0`: go to `IDLE` and pulse `flush_done_out` with no line.
  - `flush_in` while in `FLUSH_WAIT` is ignored.
- **Reset** (`Clear_in`): `Out_valid=0`, `Out_data=0`, `Out_count=0`, `Overflow_out=0`, `flush_done_out=0`, `acc_cnt=0`, `skid_cnt=0`, state `IDLE`. `stall_out` is therefore 0 after reset. Reset mid-line discards all held records.

## Timing
- The accumulator is written on the cycle a record is present. A completed line shows `Out_valid=1` on the next cycle.
- `Out_data`, `Out_count` and `Out_valid` hold stable while `Out_valid & !Out_ready`.
- Back-to-back lines: a handshake in cycle t together with a full accumulator gives the new line valid at t+1, with no bubble.
- Throughput: one record per cycle sustained when `Out_ready` is held high.
- `stall_out` responds to state in the same cycle. The skid drains one entry per cycle once the accumulator has room.
- A partial flush line appears the cycle after the `FLUSH_WAIT` conditions hold. `flush_done_out` pulses in that same cycle.

## Configuration
- **`SMEM_PACKER_PERF_EN` defined**: adds outputs `Perf_lines` (32-bit, counts handshakes) and `Perf_stall_cycles` (32-bit, counts cycles with `stall_out=1`). Both clear on `Clear_in` and wrap at 2^32.
- **Macro undefined**: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Basic packing**: reset, then 8 records 0x1..0x8 on consecutive cycles with `Out_ready=1` → two lines, `Out_count=4`; slot 0 = 0x1 then 0x5; `stall_out` never high.
- **Backpressure**: `Out_ready=0`, stream 12 records from the FIFO model → `stall_out` rises after record 8; no record lost; `Overflow_out=0`. Release `Out_ready` → lines 1–3 in order.
- **Partial flush**: 3 records, then `flush_in` with FIFO empty → one line with `Out_count=3`, slot 3 = 0, and `flush_done_out` pulse.
- **Empty flush**: `flush_in` with nothing held → `flush_done_out` pulse, `Out_valid` stays 0.
- **Forced overflow**: inject `Data_valid_in` while `skid_cnt=2` → `Overflow_out=1`, held until `Clear_in`.
- **Mid-line reset**: `Clear_in` with `acc_cnt=2` and `Out_valid=1` → all outputs 0 next cycle; next 4 records form a clean line.

Source files
------------

// File: rtl/smem_result_packer.sv
// smem_result_packer: packs 65-bit SMEM FIFO records into PACK_COUNT-record
// lines for the host write path, with a 2-entry skid, stall and flush.
//
// Ports:
//   Clk, Clear_in          clock, synchronous active-high reset
//   Data_in/Data_valid_in  record from the FIFO read port
//   Empty_in               FIFO empty flag
//   stall_out              to FIFO stall; high = no pop this cycle
//   flush_in               request to emit a partial line
//   Out_data/Out_count     packed line (slot 0 oldest) and valid slot count
//   Out_valid/Out_ready    output handshake
//   Overflow_out           sticky: record arrived with skid full
//   flush_done_out         one-cycle pulse when a flush completes
// Optional macro SMEM_PACKER_PERF_EN adds Perf_lines and Perf_stall_cycles.
module smem_result_packer #(
    parameter int DATA_WIDTH  = 65,
    parameter int PACK_COUNT  = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                             Clk,
    input  logic                             Clear_in,
    input  logic [DATA_WIDTH-1:0]            Data_in,
    input  logic                             Data_valid_in,
    input  logic                             Empty_in,
    output logic                             stall_out,
    input  logic                             flush_in,
    output logic [DATA_WIDTH*PACK_COUNT-1:0] Out_data,
    output logic [COUNT_WIDTH-1:0]           Out_count,
    output logic                             Out_valid,
    input  logic                             Out_ready,
    output logic                             Overflow_out,
    output logic                             flush_done_out
`ifdef SMEM_PACKER_PERF_EN
    ,
    output logic [31:0]                      Perf_lines,
    output logic [31:0]                      Perf_stall_cycles
`endif
);

    localparam int LINE_W = DATA_WIDTH * PACK_COUNT;
    localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(PACK_COUNT);

    typedef enum logic {
        IDLE,
        FLUSH_WAIT
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q [PACK_COUNT];
    logic [DATA_WIDTH-1:0]  acc_d [PACK_COUNT];
    logic [COUNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic [DATA_WIDTH-1:0]  skid_q [2];
    logic [DATA_WIDTH-1:0]  skid_d [2];
    logic [1:0]             skid_cnt_q, skid_cnt_d;
    logic [LINE_W-1:0]      out_data_q, out_data_d;
    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   flush_done_q, flush_done_d;

    logic                   handshake;
    logic                   out_free;
    logic                   acc_full;
    logic                   line_xfer;
    logic                   acc_room;
    logic                   take_skid;
    logic                   take_in;
    logic                   push_skid;
    logic                   rec_valid;
    logic [DATA_WIDTH-1:0]  rec_data;
    logic                   flush_go;
    logic                   emit;
    logic [LINE_W-1:0]      line_bits;

    assign handshake = out_valid_q && Out_ready;
    assign out_free  = !out_valid_q || handshake;
    assign acc_full  = (acc_cnt_q == FULL_CNT);
    assign line_xfer = acc_full && out_free;
    // A full accumulator can still take a record in the cycle it empties.
    assign acc_room  = !acc_full || line_xfer;
    assign take_skid = (skid_cnt_q != 2'd0) && acc_room;
    assign take_in   = Data_valid_in && (skid_cnt_q == 2'd0) && acc_room;
    assign push_skid = Data_valid_in && !take_in && (skid_cnt_q != 2'd2);
    assign rec_valid = take_skid || take_in;
    assign rec_data  = take_skid ? skid_q[0] : Data_in;

    assign flush_go = (state_q == FLUSH_WAIT) && Empty_in && !Data_valid_in
                      && (skid_cnt_q == 2'd0) && out_free;
    assign emit     = line_xfer || (flush_go && (acc_cnt_q != '0));

    assign stall_out = (skid_cnt_q != 2'd0) || (acc_full && !out_free);

    // Unfilled slots of a partial line read as zero.
    always_comb begin
        line_bits = '0;
        for (int k = 0; k < PACK_COUNT; k++) begin
            if (COUNT_WIDTH'(k) < acc_cnt_q) begin
                line_bits[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k];
            end
        end
    end

    always_comb begin
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        if (emit) begin
            acc_cnt_d = '0;
        end
        if (rec_valid) begin
            for (int k = 0; k < PACK_COUNT; k++) begin
                if (COUNT_WIDTH'(k) == acc_cnt_d) begin
                    acc_d[k] = rec_data;
                end
            end
            acc_cnt_d = acc_cnt_d + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        if (take_skid) begin
            skid_d[0]  = skid_q[1];
            skid_cnt_d = skid_cnt_d - 2'd1;
        end
        if (push_skid) begin
            if (skid_cnt_d == 2'd0) begin
                skid_d[0] = Data_in;
            end else begin
                skid_d[1] = Data_in;
            end
            skid_cnt_d = skid_cnt_d + 2'd1;
        end
    end

    always_comb begin
        overflow_d  = overflow_q || (Data_valid_in && (skid_cnt_q == 2'd2));
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        if (emit) begin
            out_data_d  = line_bits;
            out_count_d = acc_cnt_q;
            out_valid_d = 1'b1;
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_in) begin
                    state_d = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (flush_go) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            state_q      <= IDLE;
            acc_cnt_q    <= '0;
            skid_cnt_q   <= '0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            flush_done_q <= 1'b0;
            for (int k = 0; k < PACK_COUNT; k++) begin
                acc_q[k] <= '0;
            end
            skid_q[0]    <= '0;
            skid_q[1]    <= '0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            skid_cnt_q   <= skid_cnt_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            flush_done_q <= flush_done_d;
            acc_q        <= acc_d;
            skid_q       <= skid_d;
        end
    end

    assign Out_data       = out_data_q;
    assign Out_count      = out_count_q;
    assign Out_valid      = out_valid_q;
    assign Overflow_out   = overflow_q;
    assign flush_done_out = flush_done_q;

`ifdef SMEM_PACKER_PERF_EN
    logic [31:0] perf_lines_q, perf_lines_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_lines_d = perf_lines_q + (handshake ? 32'd1 : 32'd0);
        perf_stall_d = perf_stall_q + (stall_out ? 32'd1 : 32'd0);
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            perf_lines_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_lines_q <= perf_lines_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign Perf_lines        = perf_lines_q;
    assign Perf_stall_cycles = perf_stall_q;
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_smem_result_packer.sv
// tb_smem_result_packer: directed bench with a queue-based line model
// and a FIFO read-port model honouring the one-cycle pop->valid latency.
module tb_smem_result_packer;

    localparam int DW = 65;
    localparam int PC = 4;
    localparam int CW = 3;
    localparam int LW = DW * PC;

    logic          Clk = 1'b0;
    logic          Clear_in = 1'b1;
    logic [DW-1:0] Data_in = '0;
    logic          Data_valid_in = 1'b0;
    logic          Empty_in = 1'b1;
    logic          stall_out;
    logic          flush_in = 1'b0;
    logic [LW-1:0] Out_data;
    logic [CW-1:0] Out_count;
    logic          Out_valid;
    logic          Out_ready = 1'b0;
    logic          Overflow_out;
    logic          flush_done_out;
`ifdef SMEM_PACKER_PERF_EN
    logic [31:0]   Perf_lines;
    logic [31:0]   Perf_stall_cycles;
`endif

    smem_result_packer #(
        .DATA_WIDTH (DW),
        .PACK_COUNT (PC),
        .COUNT_WIDTH(CW)
    ) dut (
        .Clk           (Clk),
        .Clear_in      (Clear_in),
        .Data_in       (Data_in),
        .Data_valid_in (Data_valid_in),
        .Empty_in      (Empty_in),
        .stall_out     (stall_out),
        .flush_in      (flush_in),
        .Out_data      (Out_data),
        .Out_count     (Out_count),
        .Out_valid     (Out_valid),
        .Out_ready     (Out_ready),
        .Overflow_out  (Overflow_out),
        .flush_done_out(flush_done_out)
`ifdef SMEM_PACKER_PERF_EN
        ,
        .Perf_lines       (Perf_lines),
        .Perf_stall_cycles(Perf_stall_cycles)
`endif
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] acc_m [$];
    logic [LW-1:0] exp_l [$];
    int            exp_c [$];
    logic [LW-1:0] got_l [$];
    int            got_c [$];
    bit            model_on = 1'b1;
    bit            direct = 1'b0;
    bit            stall_seen = 1'b0;
    bit            hold_v = 1'b0;
    logic [LW-1:0] hold_d;
    logic [CW-1:0] hold_c;

    task automatic chk(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] slot(input logic [LW-1:0] l,
                                           input int k);
        return l[k*DW +: DW];
    endfunction

    // Expected line = the pending records in arrival order, rest zero.
    task automatic cut_line();
        logic [LW-1:0] l;
        l = '0;
        foreach (acc_m[k]) l[k*DW +: DW] = acc_m[k];
        exp_l.push_back(l);
        exp_c.push_back(acc_m.size());
        acc_m.delete();
    endtask

    // Compare process: every accepted line against the model, output
    // stability under backpressure, and the record stream into the model.
    always @(negedge Clk) begin
        if (Clear_in || !model_on) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", LW'(Out_valid), LW'(1));
                chk("hold_data", Out_data, hold_d);
                chk("hold_count", LW'(Out_count), LW'(hold_c));
            end
            if (Out_valid && Out_ready) begin
                if (exp_l.size() == 0) begin
                    chk("unexpected_line", LW'(exp_l.size()), LW'(1));
                end else begin
                    chk("line_data", Out_data, exp_l.pop_front());
                    chk("line_count", LW'(Out_count), LW'(exp_c.pop_front()));
                end
                got_l.push_back(Out_data);
                got_c.push_back(int'(Out_count));
            end
            chk("no_overflow", LW'(Overflow_out), LW'(0));
            hold_v = Out_valid && !Out_ready;
            hold_d = Out_data;
            hold_c = Out_count;
            if (Data_valid_in) begin
                acc_m.push_back(Data_in);
                if (acc_m.size() == PC) cut_line();
            end
            if (stall_out) stall_seen = 1'b1;
        end
    end

    // One clock; FIFO model pops when stall is low and presents the
    // record one cycle later.
    task automatic step();
        bit pop;
        @(negedge Clk);
        pop = !stall_out && (fifo_q.size() > 0);
        @(posedge Clk);
        #1;
        if (!direct) begin
            if (pop) begin
                Data_in = fifo_q.pop_front();
                Data_valid_in = 1'b1;
            end else begin
                Data_valid_in = 1'b0;
            end
            Empty_in = (fifo_q.size() == 0);
        end
    endtask

    task automatic do_clear();
        Clear_in = 1'b1;
        Data_valid_in = 1'b0;
        flush_in = 1'b0;
        acc_m.delete();
        exp_l.delete();
        exp_c.delete();
        step();
        Clear_in = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (fifo_q.size() == 0 && !Data_valid_in && exp_l.size() == 0
                && !Out_valid && !stall_out) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(name, LW'(ok), LW'(1));
    endtask

    task automatic do_flush(input string name, input bit exp_line,
                            input int exp_cnt);
        bit seen;
        if (acc_m.size() > 0) cut_line();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (flush_done_out) begin
                seen = 1'b1;
                chk({name, "_valid"}, LW'(Out_valid), LW'(exp_line));
                if (exp_line) chk({name, "_count"}, LW'(Out_count), LW'(exp_cnt));
                break;
            end
            @(posedge Clk);
            #1;
        end
        chk({name, "_done"}, LW'(seen), LW'(1));
        step();
        chk({name, "_pulse"}, LW'(flush_done_out), LW'(0));
    endtask

    initial begin
        step();
        do_clear();
        @(negedge Clk);
        chk("rst_valid", LW'(Out_valid), LW'(0));
        chk("rst_data", Out_data, LW'(0));
        chk("rst_count", LW'(Out_count), LW'(0));
        chk("rst_ovf", LW'(Overflow_out), LW'(0));
        chk("rst_done", LW'(flush_done_out), LW'(0));
        chk("rst_stall", LW'(stall_out), LW'(0));

        // Basic packing
        got_l.delete(); got_c.delete();
        stall_seen = 1'b0;
        Out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        drain("basic_drain");
        chk("basic_lines", LW'(got_l.size()), LW'(2));
        chk("basic_l0_s0", LW'(slot(got_l[0], 0)), LW'(1));
        chk("basic_l1_s0", LW'(slot(got_l[1], 0)), LW'(5));
        chk("basic_l1_c", LW'(got_c[1]), LW'(4));
        chk("basic_stall", LW'(stall_seen), LW'(0));

        // Backpressure
        got_l.delete(); got_c.delete();
        stall_seen = 1'b0;
        Out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) fifo_q.push_back(DW'(i));
        for (int i = 0; i < 20; i++) step();
        chk("bp_stall", LW'(stall_out), LW'(1));
        chk("bp_ovf", LW'(Overflow_out), LW'(0));
        chk("bp_nolines", LW'(got_l.size()), LW'(0));
        Out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_lines", LW'(got_l.size()), LW'(3));
        chk("bp_l0_s0", LW'(slot(got_l[0], 0)), LW'(1));
        chk("bp_l1_s0", LW'(slot(got_l[1], 0)), LW'(5));
        chk("bp_l2_s3", LW'(slot(got_l[2], 3)), LW'(12));

        // Partial flush
        got_l.delete(); got_c.delete();
        fifo_q.push_back(DW'(32'h11));
        fifo_q.push_back(DW'(32'h12));
        fifo_q.push_back(DW'(32'h13));
        drain("pf_drain");
        do_flush("pf", 1'b1, 3);
        drain("pf_drain2");
        chk("pf_lines", LW'(got_l.size()), LW'(1));
        chk("pf_s2", LW'(slot(got_l[0], 2)), LW'(32'h13));
        chk("pf_s3", LW'(slot(got_l[0], 3)), LW'(0));
        chk("pf_c", LW'(got_c[0]), LW'(3));

        // Empty flush
        got_l.delete(); got_c.delete();
        do_flush("ef", 1'b0, 0);
        for (int i = 0; i < 4; i++) step();
        chk("ef_nolines", LW'(got_l.size()), LW'(0));
        chk("ef_valid", LW'(Out_valid), LW'(0));

        // Forced overflow: drive records ignoring stall
        model_on = 1'b0;
        direct = 1'b1;
        Out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            Data_in = DW'(32'h100 + i);
            Data_valid_in = 1'b1;
            step();
        end
        Data_valid_in = 1'b0;
        step();
        chk("ovf_set", LW'(Overflow_out), LW'(1));
        Out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("ovf_sticky", LW'(Overflow_out), LW'(1));
        do_clear();
        direct = 1'b0;
        Empty_in = 1'b1;
        @(negedge Clk);
        chk("ovf_clr", LW'(Overflow_out), LW'(0));
        chk("ovf_clr_stall", LW'(stall_out), LW'(0));
        model_on = 1'b1;

        // Mid-line reset
        Out_ready = 1'b0;
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(32'h21 + i));
        for (int i = 0; i < 12; i++) step();
        chk("mid_valid_pre", LW'(Out_valid), LW'(1));
        do_clear();
        @(negedge Clk);
        chk("mid_valid", LW'(Out_valid), LW'(0));
        chk("mid_data", Out_data, LW'(0));
        chk("mid_count", LW'(Out_count), LW'(0));
        chk("mid_ovf", LW'(Overflow_out), LW'(0));
        chk("mid_done", LW'(flush_done_out), LW'(0));
        chk("mid_stall", LW'(stall_out), LW'(0));
        got_l.delete(); got_c.delete();
        Out_ready = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(32'h31 + i));
        drain("mid_drain");
        chk("mid_lines", LW'(got_l.size()), LW'(1));
        chk("mid_s0", LW'(slot(got_l[0], 0)), LW'(32'h31));
        chk("mid_s3", LW'(slot(got_l[0], 3)), LW'(32'h34));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
